psr_flag_unit: RTL and testbench

Program-status flag stage directly downstream of the ALU. It captures the ALU's 4-bit `{N,Z,C,V}` result flags under control-unit strobes, applies the per-opcode update mask, and holds the architectural flags. It feeds the carry back to the ALU `C_in` and evaluates ARM condition codes for the control unit with a registered, one-cycle-latency handshake. It also holds one shadow copy of the flags (SPSR-like) for save/restore.

---
 rtl/psr_flag_unit.sv | 58 +++++
 tb/tb_psr_flag_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/psr_flag_unit.sv
// psr_flag_unit: captures masked ALU NZCV flags, keeps an SPSR-like shadow copy,
// and evaluates ARM condition codes against the next-state flags with a registered result.
module psr_flag_unit (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] alu_flags,
    input  logic [4:0] alu_op,
    input  logic       s_bit,
    input  logic       flag_ld,
    input  logic       save,
    input  logic       restore,
    input  logic [3:0] cond,
    input  logic       cond_req,
    output logic [3:0] flags,
    output logic [3:0] saved_flags,
    output logic       c_in,
    output logic       cond_valid,
    output logic       cond_pass
);
    logic       upd, arith, n, z, c, v, base, pass_nx;
    logic [3:0] upd_flags, flags_nx, saved_nx;
    always_comb begin
        upd       = flag_ld & ~alu_op[4] & (s_bit | alu_op[4:2] == 3'b010);
        arith     = alu_op inside {[5'd2:5'd7], 5'd10, 5'd11};
        // logical ops leave the ALU's V output stale, so V is kept
        upd_flags = arith ? alu_flags : {alu_flags[3:1], flags[0]};
        flags_nx  = restore ? saved_flags : upd ? upd_flags : flags;
        saved_nx  = save ? flags : saved_flags;
        {n, z, c, v} = flags_nx;
        // odd condition codes are the inverse of the even one below them, 1111 included
        base = 1'b1;
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & ~z;
            3'd5: base = n == v;
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        pass_nx = base ^ cond[0];
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags       <= 4'b0000;
            saved_flags <= 4'b0000;
            cond_valid  <= 1'b0;
            cond_pass   <= 1'b0;
        end else begin
            flags       <= flags_nx;
            saved_flags <= saved_nx;
            cond_valid  <= cond_req;
            if (cond_req) cond_pass <= pass_nx;
        end
    end
    assign c_in = flags[1];
endmodule

// File: tb/tb_psr_flag_unit.sv
// tb_psr_flag_unit: directed and randomized checks of psr_flag_unit against a behavioural model.
module tb_psr_flag_unit;
    logic       clk = 0, reset_n = 1;
    logic [3:0] alu_flags = 0, cond = 0;
    logic [4:0] alu_op = 0;
    logic       s_bit = 0, flag_ld = 0, save = 0, restore = 0, cond_req = 0;
    logic [3:0] flags, saved_flags;
    logic       c_in, cond_valid, cond_pass;
    int         checks = 0, errors = 0;
    logic [3:0] m_flags = 0, m_saved = 0;
    logic       m_valid = 0, m_pass = 0;

    psr_flag_unit dut (
        .clk(clk), .reset_n(reset_n), .alu_flags(alu_flags), .alu_op(alu_op),
        .s_bit(s_bit), .flag_ld(flag_ld), .save(save), .restore(restore),
        .cond(cond), .cond_req(cond_req), .flags(flags), .saved_flags(saved_flags),
        .c_in(c_in), .cond_valid(cond_valid), .cond_pass(cond_pass)
    );

    always #5 clk = ~clk;

    function automatic logic holds(input logic [3:0] cc, input logic [3:0] f);
        logic fn, fz, fc, fv;
        fn = f[3]; fz = f[2]; fc = f[1]; fv = f[0];
        case (cc)
            4'd0:  return fz;
            4'd1:  return !fz;
            4'd2:  return fc;
            4'd3:  return !fc;
            4'd4:  return fn;
            4'd5:  return !fn;
            4'd6:  return fv;
            4'd7:  return !fv;
            4'd8:  return fc && !fz;
            4'd9:  return !fc || fz;
            4'd10: return fn == fv;
            4'd11: return fn != fv;
            4'd12: return !fz && fn == fv;
            4'd13: return fz || fn != fv;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic idle();
        flag_ld = 0; save = 0; restore = 0; cond_req = 0; s_bit = 0;
    endtask

    task automatic alu(input logic [4:0] op, input logic s, input logic [3:0] f);
        alu_op = op; s_bit = s; alu_flags = f; flag_ld = 1;
    endtask

    // advance the model with the inputs currently applied, then clock the DUT
    task automatic tick();
        logic       is_test, upd, arith;
        logic [3:0] nx;
        is_test = alu_op inside {5'd8, 5'd9, 5'd10, 5'd11};
        upd     = flag_ld && alu_op < 5'd16 && (s_bit || is_test);
        arith   = (alu_op >= 5'd2 && alu_op <= 5'd7) || alu_op == 5'd10 || alu_op == 5'd11;
        nx = m_flags;
        if (upd) nx = arith ? alu_flags : {alu_flags[3:1], m_flags[0]};
        if (restore) nx = m_saved;
        m_valid = cond_req;
        if (cond_req) m_pass = holds(cond, nx);
        if (save) m_saved = m_flags;
        m_flags = nx;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 reset_n = 0;
        #1;
        checks++;
        if ({flags, saved_flags, c_in, cond_valid, cond_pass} !== 11'd0) begin
            errors++;
            $display("FAIL reset_initial got %b expected 0", {flags, saved_flags, c_in, cond_valid, cond_pass});
        end
        @(negedge clk) reset_n = 1;
        alu(5'd4, 1, 4'b0111); cond = 4'd14; cond_req = 1;
        tick();
        checks++;
        if (flags !== 4'b0111 || cond_valid !== 1 || cond_pass !== 1) begin
            errors++;
            $display("FAIL pre_reset_state got f=%b v=%b p=%b expected f=0111 v=1 p=1", flags, cond_valid, cond_pass);
        end
        idle(); cond_req = 1;
        #2 reset_n = 0;
        #1;
        checks++;
        if ({flags, saved_flags, c_in, cond_valid, cond_pass} !== 11'd0) begin
            errors++;
            $display("FAIL reset_async got %b expected 0", {flags, saved_flags, c_in, cond_valid, cond_pass});
        end
        @(posedge clk); #1;
        checks++;
        if (cond_valid !== 0) begin
            errors++;
            $display("FAIL reset_hold_valid got %b expected 0", cond_valid);
        end
        @(negedge clk) reset_n = 1;
        cond_req = 0;
        m_flags = 0; m_saved = 0; m_valid = 0; m_pass = 0;
        tick();
        checks++;
        if (cond_valid !== 0 || flags !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release got v=%b f=%b expected v=0 f=0000", cond_valid, flags);
        end
    endtask

    task automatic test_adds();
        idle(); alu(5'b00100, 1, 4'b0111);
        tick();
        checks++;
        if (flags !== 4'b0111 || c_in !== 1) begin
            errors++;
            $display("FAIL adds got f=%b c_in=%b expected f=0111 c_in=1", flags, c_in);
        end
    endtask

    task automatic test_v_preserve();
        idle(); alu(5'b01010, 0, 4'b0001);
        tick();
        idle(); alu(5'b01101, 1, 4'b1010);
        tick();
        checks++;
        if (flags !== 4'b1011) begin
            errors++;
            $display("FAIL v_preserve got %b expected 1011", flags);
        end
    endtask

    task automatic test_sbit();
        idle(); alu(5'b01010, 0, 4'b0100);
        tick();
        checks++;
        if (flags !== 4'b0100) begin
            errors++;
            $display("FAIL sbit_cmp got %b expected 0100", flags);
        end
        idle(); alu(5'b10001, 0, 4'b1011);
        tick();
        checks++;
        if (flags !== 4'b0100) begin
            errors++;
            $display("FAIL sbit_special got %b expected 0100", flags);
        end
        idle(); alu(5'b00100, 0, 4'b1011);
        tick();
        checks++;
        if (flags !== 4'b0100) begin
            errors++;
            $display("FAIL sbit_add_s0 got %b expected 0100", flags);
        end
    endtask

    task automatic test_bypass();
        idle(); alu(5'b01010, 0, 4'b0000);
        tick();
        idle(); alu(5'b01010, 0, 4'b0100); cond = 4'd0; cond_req = 1;
        tick();
        checks++;
        if (cond_valid !== 1 || cond_pass !== 1) begin
            errors++;
            $display("FAIL bypass_eq got v=%b p=%b expected v=1 p=1", cond_valid, cond_pass);
        end
        idle(); alu(5'b01010, 0, 4'b1001);
        tick();
        idle();
        for (int i = 0; i < 16; i++) begin
            cond = 4'(i); cond_req = 1;
            tick();
            checks++;
            if (cond_valid !== 1 || cond_pass !== m_pass) begin
                errors++;
                $display("FAIL cond_sweep_%0d got v=%b p=%b expected v=1 p=%b", i, cond_valid, cond_pass, m_pass);
            end
        end
        cond = 4'd14; cond_req = 1;
        tick();
        idle();
        repeat (2) begin
            tick();
            checks++;
            if (cond_valid !== 0 || cond_pass !== 1) begin
                errors++;
                $display("FAIL result_hold got v=%b p=%b expected v=0 p=1", cond_valid, cond_pass);
            end
        end
    endtask

    task automatic test_save_restore();
        idle(); alu(5'b01010, 0, 4'b1100);
        tick();
        idle(); save = 1;
        tick();
        checks++;
        if (saved_flags !== 4'b1100) begin
            errors++;
            $display("FAIL save got %b expected 1100", saved_flags);
        end
        idle(); alu(5'b01010, 0, 4'b0010);
        tick();
        checks++;
        if (flags !== 4'b0010) begin
            errors++;
            $display("FAIL cmp_before_restore got %b expected 0010", flags);
        end
        idle(); restore = 1; alu(5'b01010, 0, 4'b0111);
        tick();
        checks++;
        if (flags !== 4'b1100) begin
            errors++;
            $display("FAIL restore_priority got %b expected 1100", flags);
        end
        idle(); alu(5'b01010, 0, 4'b1000);
        tick();
        idle(); save = 1;
        tick();
        idle(); alu(5'b01010, 0, 4'b0001);
        tick();
        idle(); save = 1; restore = 1;
        tick();
        checks++;
        if (flags !== 4'b1000 || saved_flags !== 4'b0001) begin
            errors++;
            $display("FAIL swap got f=%b s=%b expected f=1000 s=0001", flags, saved_flags);
        end
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            alu_flags = 4'($urandom);
            alu_op    = 5'($urandom);
            s_bit     = 1'($urandom);
            flag_ld   = 1'($urandom);
            save      = ($urandom % 4) == 0;
            restore   = ($urandom % 4) == 0;
            cond      = 4'($urandom);
            cond_req  = ($urandom % 3) != 0;
            tick();
            checks++;
            if (flags !== m_flags || saved_flags !== m_saved || c_in !== m_flags[1]
                || cond_valid !== m_valid || cond_pass !== m_pass) begin
                errors++;
                $display("FAIL random_%0d got f=%b s=%b c=%b v=%b p=%b expected f=%b s=%b c=%b v=%b p=%b",
                         i, flags, saved_flags, c_in, cond_valid, cond_pass,
                         m_flags, m_saved, m_flags[1], m_valid, m_pass);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_adds();
        test_v_preserve();
        test_sbit();
        test_bypass();
        test_save_restore();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
